// File: rtl/pulse_tx_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_tx_gen_if
// Description : AXI-Stream sample channel (sc16 I/Q beats with per-pulse TLAST)
//               carried from the probe-pulse transmitter to its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_tx_gen_if #(
    parameter int IQ_W = 16
);
    logic [2*IQ_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/pulse_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : pulse_tx_gen
// Description : Probe-pulse transmitter. Emits a burst of identical BPSK pulses
//               generated from a reseeded 10-bit PN LFSR (x^10+x^7+1), one
//               TLAST per pulse, separated by a programmable idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_tx_gen #(
    parameter logic [9:0] LFSR_SEED = 10'h3FF,
    parameter int         IQ_W      = 16
) (
    input  wire logic          ap_clk,
    input  wire logic          ap_rst_n,
    input  wire logic          start,
    input  wire logic          abort,
    input  wire logic [15:0]   seq_len_V,
    input  wire logic [31:0]   avg_size_V,
    input  wire logic [15:0]   amplitude_V,
    input  wire logic [15:0]   gap_len_V,
    pulse_tx_gen_if.master     o_data,
    output logic               busy,
    output logic               done,
    output logic [31:0]        pulse_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [9:0]          seq_len_q, seq_len_d;
    logic [31:0]         avg_q, avg_d;
    logic [IQ_W-2:0]     amp_q, amp_d;
    logic [15:0]         gap_q, gap_d;
    logic [15:0]         gap_cnt_q, gap_cnt_d;
    logic [9:0]          smp_q, smp_d;
    logic [9:0]          lfsr_q, lfsr_d;
    logic [2*IQ_W-1:0]   tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                abort_seen_q, abort_seen_d;

    logic                hs;
    logic [9:0]          lfsr_adv;
    logic                unused_bits;

    // Bits of the setting words that carry no meaning for this block.
    assign unused_bits = ^{seq_len_V[15:10], amplitude_V[15]};

    // BPSK mapping: PN bit 1 sends -magnitude on I, 0 sends +magnitude; Q is 0.
    function automatic logic [2*IQ_W-1:0] map_sample(input logic b, input logic [IQ_W-2:0] mag);
        logic [IQ_W-1:0] m;
        logic [IQ_W-1:0] i_val;
        m     = {1'b0, mag};
        i_val = b ? (IQ_W'(0) - m) : m;
        return {i_val, {IQ_W{1'b0}}};
    endfunction

    assign hs       = tvalid_q && o_data.tready;
    assign lfsr_adv = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[9:1]};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        seq_len_d    = seq_len_q;
        avg_d        = avg_q;
        amp_d        = amp_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        smp_d        = smp_q;
        lfsr_d       = lfsr_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        done_d       = 1'b0;
        cnt_d        = cnt_q;
        abort_seen_d = abort_seen_q;

        case (state_q)
            S_IDLE: begin
                abort_seen_d = 1'b0;
                if (start && (seq_len_V[9:0] != 10'd0)) begin
                    seq_len_d = seq_len_V[9:0];
                    avg_d     = avg_size_V;
                    amp_d     = amplitude_V[IQ_W-2:0];
                    gap_d     = gap_len_V;
                    cnt_d     = 32'd0;
                    smp_d     = 10'd0;
                    lfsr_d    = LFSR_SEED;
                    tdata_d   = map_sample(LFSR_SEED[0], amplitude_V[IQ_W-2:0]);
                    tvalid_d  = 1'b1;
                    tlast_d   = (seq_len_V[9:0] == 10'd1);
                    state_d   = S_PULSE;
                end
            end

            S_PULSE: begin
                if (abort) begin
                    abort_seen_d = 1'b1;
                end
                if (hs) begin
                    if (tlast_q) begin
                        cnt_d = cnt_q + 32'd1;
                        if (abort_seen_q || abort ||
                            ((avg_q != 32'd0) && ((cnt_q + 32'd1) == avg_q))) begin
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            tdata_d  = '0;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end else if (gap_q == 16'd0) begin
                            // Back-to-back pulse: valid stays high, PN restarts.
                            smp_d   = 10'd0;
                            lfsr_d  = LFSR_SEED;
                            tdata_d = map_sample(LFSR_SEED[0], amp_q);
                            tlast_d = (seq_len_q == 10'd1);
                        end else begin
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            tdata_d   = '0;
                            gap_cnt_d = 16'd0;
                            state_d   = S_GAP;
                        end
                    end else begin
                        smp_d   = smp_q + 10'd1;
                        lfsr_d  = lfsr_adv;
                        tdata_d = map_sample(lfsr_adv[0], amp_q);
                        tlast_d = ((smp_q + 10'd1) == (seq_len_q - 10'd1));
                    end
                end
            end

            S_GAP: begin
                if (abort) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (gap_cnt_q == (gap_q - 16'd1)) begin
                    // Last idle cycle: present the first sample of the next pulse.
                    smp_d    = 10'd0;
                    lfsr_d   = LFSR_SEED;
                    tdata_d  = map_sample(LFSR_SEED[0], amp_q);
                    tvalid_d = 1'b1;
                    tlast_d  = (seq_len_q == 10'd1);
                    state_d  = S_PULSE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end

            S_DONE: begin
                abort_seen_d = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any pulse in flight.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= S_IDLE;
            seq_len_q    <= 10'd0;
            avg_q        <= 32'd0;
            amp_q        <= '0;
            gap_q        <= 16'd0;
            gap_cnt_q    <= 16'd0;
            smp_q        <= 10'd0;
            lfsr_q       <= LFSR_SEED;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= 32'd0;
            abort_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_len_q    <= seq_len_d;
            avg_q        <= avg_d;
            amp_q        <= amp_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            smp_q        <= smp_d;
            lfsr_q       <= lfsr_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            abort_seen_q <= abort_seen_d;
        end
    end

    assign o_data.tdata  = tdata_q;
    assign o_data.tvalid = tvalid_q;
    assign o_data.tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pulse_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_tx_gen
// Description : Directed self-checking bench for pulse_tx_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_tx_gen;

    logic        ap_clk   = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        start    = 1'b0;
    logic        abort    = 1'b0;
    logic [15:0] seq_len_V   = 16'd0;
    logic [31:0] avg_size_V  = 32'd0;
    logic [15:0] amplitude_V = 16'd0;
    logic [15:0] gap_len_V   = 16'd0;
    logic        busy;
    logic        done;
    logic [31:0] pulse_cnt;

    pulse_tx_gen_if #(.IQ_W(16)) o_if ();

    pulse_tx_gen #(.LFSR_SEED(10'h3FF), .IQ_W(16)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .start       (start),
        .abort       (abort),
        .seq_len_V   (seq_len_V),
        .avg_size_V  (avg_size_V),
        .amplitude_V (amplitude_V),
        .gap_len_V   (gap_len_V),
        .o_data      (o_if),
        .busy        (busy),
        .done        (done),
        .pulse_cnt   (pulse_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_q [0:1022];
    logic [32:0] beats[$];
    int          beat_cyc[$];
    int          done_cnt;
    int          lowcnt;
    int          stall_bad;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference PN sample sequence from the seed, independent of the DUT.
    task automatic build_ref(input logic [14:0] amp);
        logic [9:0]  l;
        logic [15:0] m;
        l = 10'h3FF;
        m = {1'b0, amp};
        for (int i = 0; i < 1023; i++) begin
            ref_q[i] = {(l[0] ? (16'h0000 - m) : m), 16'h0000};
            l = {l[0] ^ l[3], l[9:1]};
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge ap_clk); #1;
        start = 1'b0;
    endtask

    // Consume beats until the burst completes (done seen, then busy low).
    task automatic run_burst(input int budget, input bit rnd, input int abort_at);
        bit          prev_stall;
        logic [32:0] prev;
        bit          fin;
        beats.delete();
        beat_cyc.delete();
        done_cnt   = 0;
        lowcnt     = 0;
        stall_bad  = 0;
        prev_stall = 1'b0;
        prev       = '0;
        fin        = 1'b0;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            if (prev_stall && !(o_if.tvalid && ({o_if.tlast, o_if.tdata} == prev)))
                stall_bad++;
            if (done) done_cnt++;
            if (busy && !o_if.tvalid && !done) lowcnt++;
            if (done_cnt > 0 && !busy) begin
                fin = 1'b1;
            end else begin
                abort       = (abort_at >= 0) && (beats.size() == abort_at);
                o_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (o_if.tvalid && o_if.tready) begin
                    beats.push_back({o_if.tlast, o_if.tdata});
                    beat_cyc.push_back(cyc);
                end
                prev_stall = o_if.tvalid && !o_if.tready;
                prev       = {o_if.tlast, o_if.tdata};
                @(posedge ap_clk); #1;
            end
        end
        abort = 1'b0;
        chk("burst_terminates", {32'd0, fin}, 33'd1);
    endtask

    initial begin
        int ones;
        int lasts;
        o_if.tready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_tvalid", {32'd0, o_if.tvalid}, 33'd0);
        chk("rst_tlast",  {32'd0, o_if.tlast},  33'd0);
        chk("rst_tdata",  {1'b0, o_if.tdata},   33'd0);
        chk("rst_busy",   {32'd0, busy},        33'd0);
        chk("rst_done",   {32'd0, done},        33'd0);
        chk("rst_cnt",    {1'b0, pulse_cnt},    33'd0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        // ---------------- 1: two pulses of 7 with gap 3 ----------------
        seq_len_V = 16'd7; amplitude_V = 16'h1000; avg_size_V = 32'd2; gap_len_V = 16'd3;
        do_start();
        chk("t1_valid_after_start", {32'd0, o_if.tvalid}, 33'd1);
        run_burst(200, 1'b0, -1);
        chk("t1_nbeats", 33'(beats.size()), 33'd14);
        if (beats.size() == 14) begin
            for (int i = 0; i < 14; i++)
                chk($sformatf("t1_beat%0d", i), beats[i],
                    {((i == 6) || (i == 13)), 32'hF000_0000});
            chk("t1_gap_spacing", 33'(beat_cyc[7] - beat_cyc[6]), 33'd4);
        end
        chk("t1_low_cycles", 33'(lowcnt), 33'd3);
        chk("t1_done_once", 33'(done_cnt), 33'd1);
        chk("t1_pulse_cnt", {1'b0, pulse_cnt}, 33'd2);

        // ---------------- 2: full-period pulse ----------------
        seq_len_V = 16'd1023; amplitude_V = 16'h0100; avg_size_V = 32'd1; gap_len_V = 16'd0;
        build_ref(15'h0100);
        do_start();
        run_burst(3000, 1'b0, -1);
        chk("t2_nbeats", 33'(beats.size()), 33'd1023);
        ones  = 0;
        lasts = 0;
        if (beats.size() == 1023) begin
            for (int i = 0; i < 1023; i++) begin
                chk($sformatf("t2_beat%0d", i), beats[i], {(i == 1022), ref_q[i]});
                if (beats[i][31:16] == 16'hFF00) ones++;
                if (beats[i][32]) lasts++;
            end
        end
        chk("t2_neg_count", 33'(ones), 33'd512);
        chk("t2_tlast_count", 33'(lasts), 33'd1);
        chk("t2_pulse_cnt", {1'b0, pulse_cnt}, 33'd1);

        // ---------------- 3: backpressure, back-to-back pulses ----------------
        seq_len_V = 16'd16; amplitude_V = 16'h2345; avg_size_V = 32'd3; gap_len_V = 16'd0;
        build_ref(15'h2345);
        do_start();
        run_burst(1000, 1'b1, -1);
        chk("t3_nbeats", 33'(beats.size()), 33'd48);
        if (beats.size() == 48) begin
            for (int i = 0; i < 48; i++)
                chk($sformatf("t3_beat%0d", i), beats[i], {((i % 16) == 15), ref_q[i % 16]});
        end
        chk("t3_stall_stable", 33'(stall_bad), 33'd0);
        chk("t3_no_valid_gaps", 33'(lowcnt), 33'd0);
        chk("t3_pulse_cnt", {1'b0, pulse_cnt}, 33'd3);

        // ---------------- 4: continuous mode with abort ----------------
        seq_len_V = 16'd4; amplitude_V = 16'h0200; avg_size_V = 32'd0; gap_len_V = 16'd2;
        build_ref(15'h0200);
        do_start();
        run_burst(500, 1'b0, 18);
        chk("t4_nbeats", 33'(beats.size()), 33'd20);
        if (beats.size() == 20)
            chk("t4_final_tlast", beats[19], {1'b1, ref_q[3]});
        chk("t4_pulse_cnt", {1'b0, pulse_cnt}, 33'd5);
        chk("t4_done_once", 33'(done_cnt), 33'd1);
        chk("t4_busy_low", {32'd0, busy}, 33'd0);

        // ---------------- 5: reset mid-pulse ----------------
        seq_len_V = 16'd10; amplitude_V = 16'h0040; avg_size_V = 32'd1; gap_len_V = 16'd0;
        build_ref(15'h0040);
        o_if.tready = 1'b1;
        do_start();
        repeat (3) begin
            @(posedge ap_clk); #1;
        end
        chk("t5_beat4_presented", {o_if.tvalid, o_if.tdata}, {1'b1, ref_q[3]});
        ap_rst_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", {32'd0, o_if.tvalid}, 33'd0);
        chk("t5_rst_busy",   {32'd0, busy},        33'd0);
        chk("t5_rst_cnt",    {1'b0, pulse_cnt},    33'd0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        chk("t5_idle_after_rst", {32'd0, o_if.tvalid}, 33'd0);
        do_start();
        run_burst(200, 1'b0, -1);
        chk("t5_nbeats", 33'(beats.size()), 33'd10);
        if (beats.size() == 10) begin
            for (int i = 0; i < 10; i++)
                chk($sformatf("t5_beat%0d", i), beats[i], {(i == 9), ref_q[i]});
        end
        chk("t5_pulse_cnt", {1'b0, pulse_cnt}, 33'd1);

        // ---------------- 6: ignored starts ----------------
        seq_len_V = 16'hFC00;
        do_start();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_zero_len_valid%0d", i), {32'd0, o_if.tvalid}, 33'd0);
            chk($sformatf("t6_zero_len_busy%0d", i),  {32'd0, busy},        33'd0);
            @(posedge ap_clk); #1;
        end
        chk("t6_zero_len_cnt", {1'b0, pulse_cnt}, 33'd1);

        seq_len_V = 16'd5; amplitude_V = 16'h0040; avg_size_V = 32'd1; gap_len_V = 16'd0;
        o_if.tready = 1'b0;
        do_start();
        seq_len_V = 16'd9; avg_size_V = 32'd4; amplitude_V = 16'h7000; gap_len_V = 16'd5;
        do_start();
        @(posedge ap_clk); #1;
        run_burst(200, 1'b0, -1);
        chk("t6_busy_start_nbeats", 33'(beats.size()), 33'd5);
        if (beats.size() == 5) begin
            for (int i = 0; i < 5; i++)
                chk($sformatf("t6_beat%0d", i), beats[i], {(i == 4), ref_q[i]});
        end
        chk("t6_pulse_cnt", {1'b0, pulse_cnt}, 33'd1);
        repeat (3) @(posedge ap_clk);
        #1;
        chk("t6_final_idle", {31'd0, busy, o_if.tvalid}, 33'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
